// File: rtl/timer_sched.sv
// Shares one countdown timer between the anti-theft FSM (req0) and an auxiliary user (req1).
// Holds the four programmable intervals, arbitrates round-robin and reports done/abort to the owner.
module timer_sched #(
    parameter logic [3:0] T_ARM_DELAY       = 4'd6,
    parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
    parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
    parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
    input  logic       clock_i,
    input  logic       reset_i,          // active-low, synchronous
    input  logic       req0_i,
    input  logic [1:0] sel0_i,
    input  logic       req1_i,
    input  logic [1:0] sel1_i,
    input  logic       prog_we_i,
    input  logic [1:0] prog_sel_i,
    input  logic [3:0] prog_value_i,
    input  logic       timer_expired_i,
    output logic [3:0] timer_value_o,
    output logic       timer_start_o,
    output logic       timer_abort_o,
    output logic       grant0_o,
    output logic       grant1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       busy_o,
    output logic       prog_err_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_e;

    state_e     state_q;
    logic       owner_q;
    logic       last_owner_q;
    logic [1:0] spent_q, spent_d;
    logic [3:0] params_q [4];
    logic [3:0] timer_value_q;
    logic       start_q, abort_q, busy_q, prog_err_q;
    logic [1:0] grant_q, done_q;

    logic [1:0] req, elig;
    logic       win, owner_req, enter_done;
    logic [1:0] win_sel;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        req        = {req1_i, req0_i};
        elig       = req & ~spent_q;
        win        = (elig == 2'b11) ? ~last_owner_q : elig[1];
        win_sel    = win ? sel1_i : sel0_i;
        owner_req  = owner_q ? req1_i : req0_i;
        enter_done = (state_q == ST_RUN) && owner_req && timer_expired_i;
        spent_d    = spent_q;
        if (enter_done) spent_d[owner_q] = 1'b1;
        // A dropped request always re-arms that requester.
        spent_d    = spent_d & req;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            spent_q       <= 2'b00;
            // NOTE: the parameter table is a handful of flops with defined power-up values, so it is reset.
            params_q[0]   <= T_ARM_DELAY;
            params_q[1]   <= T_DRIVER_DELAY;
            params_q[2]   <= T_PASSENGER_DELAY;
            params_q[3]   <= T_ALARM_ON;
            timer_value_q <= 4'd0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            prog_err_q    <= 1'b0;
            grant_q       <= 2'b00;
            done_q        <= 2'b00;
        end else begin
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 2'b00;
            prog_err_q <= 1'b0;
            spent_q    <= spent_d;

            // The interval for this cycle's load is read before the write lands.
            if (prog_we_i) begin
                if (prog_value_i != 4'd0) params_q[prog_sel_i] <= prog_value_i;
                else                      prog_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (elig != 2'b00) begin
                        state_q       <= ST_LOAD;
                        owner_q       <= win;
                        timer_value_q <= params_q[win_sel];
                        start_q       <= 1'b1;
                        busy_q        <= 1'b1;
                        grant_q       <= win ? 2'b10 : 2'b01;
                    end
                end
                ST_LOAD, ST_RUN: begin
                    if (!owner_req) begin
                        // Abort takes priority over a coincident expiry.
                        state_q      <= ST_IDLE;
                        abort_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        grant_q      <= 2'b00;
                        last_owner_q <= owner_q;
                    end else if (enter_done) begin
                        state_q          <= ST_DONE;
                        done_q[owner_q]  <= 1'b1;
                        last_owner_q     <= owner_q;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= 2'b00;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign timer_value_o = timer_value_q;
    assign timer_start_o = start_q;
    assign timer_abort_o = abort_q;
    assign grant0_o      = grant_q[0];
    assign grant1_o      = grant_q[1];
    assign done0_o       = done_q[0];
    assign done1_o       = done_q[1];
    assign busy_o        = busy_q;
    assign prog_err_o    = prog_err_q;

endmodule
